// File: rtl/id_issue_pkg.sv
// id_issue_pkg: shared definitions for the decode/issue stage.
//  - opcode class codes (opcode[6:4])
//  - instruction field bit positions
//  - control bundle struct, its bubble value and the class decoder
package id_issue_pkg;

    // Register address width; the instruction format fixes rd/rs at 4 bits.
    localparam int REG_AW = 4;

    // Instruction field positions: [31:25]opcode [24:21]rd [20:17]rs [16]immf [15:0]imm
    localparam int OPC_LO   = 25;
    localparam int CLS_LO   = 29;   // opcode[6:4] selects the class
    localparam int RD_LO    = 21;
    localparam int RS_LO    = 17;
    localparam int IMMF_BIT = 16;
    localparam int IMM_LO   = 0;

    typedef enum logic [2:0] {
        CLS_INTE  = 3'd0,
        CLS_LOGIC = 3'd1,
        CLS_SHIFT = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4,
        CLS_BR    = 3'd5
    } op_cls_e;

    // One-hot (or all-zero for NOP) control bundle handed to ex.
    typedef struct packed {
        logic inte;
        logic lgc;
        logic shift;
        logic ld;
        logic st;
        logic br;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t decode_ctrl(input logic [2:0] cls);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (cls)
            CLS_INTE:  c.inte  = 1'b1;
            CLS_LOGIC: c.lgc   = 1'b1;
            CLS_SHIFT: c.shift = 1'b1;
            CLS_LD:    c.ld    = 1'b1;
            CLS_ST:    c.st    = 1'b1;
            CLS_BR:    c.br    = 1'b1;
            default:   c       = CTRL_BUBBLE;   // unused classes decode as NOP
        endcase
        return c;
    endfunction

    // Classes that produce a register result.
    function automatic logic is_writer(input ctrl_t c);
        return c.inte | c.lgc | c.shift | c.ld;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NUM_REGS x DATA_W register file.
//  - two combinational read ports (a, b) with write-first bypass
//  - one write port, committed on the rising edge
//  - synchronous active-low clear; writes are ignored while rst==0
// Ports:
//  clk, rst                 clock, synchronous active-low reset
//  we_i, waddr_i, wdata_i   write port
//  raddr_a_i / rdata_a_o    read port a
//  raddr_b_i / rdata_b_o    read port b
module id_regfile
    import id_issue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) regs_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-first: a same-cycle writeback is visible to the reader.
    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/id_issue.sv
// id_issue: decode/issue stage in front of ex.
//  Decodes inst_i, reads rd/rs from id_regfile and loads the issue register
//  that drives every ex-facing output (1-cycle fetch-to-ex latency). ex's
//  writeback is written into the register file.
// Ports:
//  clk, rst                     clock, synchronous active-low reset
//  inst_v_i, inst_i, pc_i       fetched instruction
//  stall_o                      fetch must hold inst_i/pc_i this cycle
//  ex_stall_i, ex_branch_i      ex stall / taken-branch flush
//  wb_en_i, wb_addr_i, wb_data_i  ex writeback
//  *_value_o, rd_addr_o, pc_value_o, opcode_o, ctrl_*_o, immf_o, rsv_o  issue bundle
module id_issue
    import id_issue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int PC_W     = 16,
    parameter int IMM_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_v_i,
    input  logic [31:0]       inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              stall_o,
    input  logic              ex_stall_i,
    input  logic              ex_branch_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] rd_value_o,
    output logic [DATA_W-1:0] rs_value_o,
    output logic [DATA_W-1:0] imm_value_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [PC_W-1:0]   pc_value_o,
    output logic [6:0]        opcode_o,
    output logic              ctrl_inte_o,
    output logic              ctrl_logic_o,
    output logic              ctrl_shift_o,
    output logic              ctrl_ld_o,
    output logic              ctrl_st_o,
    output logic              ctrl_br_o,
    output logic              immf_o,
    output logic              rsv_o
);

    // ---------------- decode ----------------
    logic [6:0]        dec_opcode;
    logic [REG_AW-1:0] dec_rd;
    logic [REG_AW-1:0] dec_rs;
    logic              dec_immf;
    logic [IMM_W-1:0]  dec_imm;
    ctrl_t             dec_ctrl;
    logic [DATA_W-1:0] dec_imm_sx;
    logic [DATA_W-1:0] rf_rd_data;
    logic [DATA_W-1:0] rf_rs_data;

    assign dec_opcode = inst_i[OPC_LO +: 7];
    assign dec_rd     = inst_i[RD_LO +: REG_AW];
    assign dec_rs     = inst_i[RS_LO +: REG_AW];
    assign dec_immf   = inst_i[IMMF_BIT];
    assign dec_imm    = inst_i[IMM_LO +: IMM_W];
    assign dec_ctrl   = decode_ctrl(inst_i[CLS_LO +: 3]);
    // Sign-extended regardless of immf; ex decides whether to use it.
    assign dec_imm_sx = {{(DATA_W-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};

    id_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_en_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (dec_rd),
        .rdata_a_o (rf_rd_data),
        .raddr_b_i (dec_rs),
        .rdata_b_o (rf_rs_data)
    );

    // ---------------- issue register ----------------
    logic [6:0]        opcode_q,   opcode_d;
    logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
    ctrl_t             ctrl_q,     ctrl_d;
    logic              immf_q,     immf_d;
    logic              rsv_q,      rsv_d;
    logic [DATA_W-1:0] rd_value_q, rd_value_d;
    logic [DATA_W-1:0] rs_value_q, rs_value_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [PC_W-1:0]   pc_q,       pc_d;

    // RAW against the instruction sitting in the issue register. Its result
    // reaches wb_* one cycle later, where the bypass picks it up, so a single
    // bubble is enough.
    logic reads_rd, reads_rs, raw_hazard;
    assign reads_rd   = !dec_ctrl.br;
    assign reads_rs   = !dec_immf;
    assign raw_hazard = rsv_q && inst_v_i &&
                        ((reads_rd && (dec_rd == rd_addr_q)) ||
                         (reads_rs && (dec_rs == rd_addr_q)));

    logic stall_c, load_inst, load_bubble;

    always_comb begin
        opcode_d    = opcode_q;
        rd_addr_d   = rd_addr_q;
        ctrl_d      = ctrl_q;
        immf_d      = immf_q;
        rsv_d       = rsv_q;
        rd_value_d  = rd_value_q;
        rs_value_d  = rs_value_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        stall_c     = 1'b0;
        load_inst   = 1'b0;
        load_bubble = 1'b0;

        if (ex_branch_i) begin
            load_bubble = 1'b1;             // flush wins even over an ex stall
        end else if (ex_stall_i) begin
            stall_c = 1'b1;                 // hold: keep register contents
        end else if (raw_hazard) begin
            load_bubble = 1'b1;
            stall_c     = 1'b1;             // fetch re-presents inst_i next cycle
        end else if (inst_v_i) begin
            load_inst = 1'b1;
        end else begin
            load_bubble = 1'b1;
        end

        if (load_inst) begin
            opcode_d   = dec_opcode;
            rd_addr_d  = dec_rd;
            ctrl_d     = dec_ctrl;
            immf_d     = dec_immf;
            rsv_d      = is_writer(dec_ctrl);
            rd_value_d = rf_rd_data;
            rs_value_d = rf_rs_data;
            imm_d      = dec_imm_sx;
            pc_d       = pc_i;
        end else if (load_bubble) begin
            opcode_d   = '0;
            rd_addr_d  = '0;
            ctrl_d     = CTRL_BUBBLE;
            immf_d     = 1'b0;
            rsv_d      = 1'b0;
            rd_value_d = '0;
            rs_value_d = '0;
            imm_d      = '0;
            pc_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            opcode_q   <= '0;
            rd_addr_q  <= '0;
            ctrl_q     <= CTRL_BUBBLE;
            immf_q     <= 1'b0;
            rsv_q      <= 1'b0;
            rd_value_q <= '0;
            rs_value_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else begin
            opcode_q   <= opcode_d;
            rd_addr_q  <= rd_addr_d;
            ctrl_q     <= ctrl_d;
            immf_q     <= immf_d;
            rsv_q      <= rsv_d;
            rd_value_q <= rd_value_d;
            rs_value_q <= rs_value_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
        end
    end

    // stall_o is combinational so fetch can hold in the same cycle; it is
    // kept low while reset is asserted.
    assign stall_o      = stall_c & rst;

    assign opcode_o     = opcode_q;
    assign rd_addr_o    = rd_addr_q;
    assign ctrl_inte_o  = ctrl_q.inte;
    assign ctrl_logic_o = ctrl_q.lgc;
    assign ctrl_shift_o = ctrl_q.shift;
    assign ctrl_ld_o    = ctrl_q.ld;
    assign ctrl_st_o    = ctrl_q.st;
    assign ctrl_br_o    = ctrl_q.br;
    assign immf_o       = immf_q;
    assign rsv_o        = rsv_q;
    assign rd_value_o   = rd_value_q;
    assign rs_value_o   = rs_value_q;
    assign imm_value_o  = imm_q;
    assign pc_value_o   = pc_q;

endmodule
